// File: rtl/icache_line_prefetcher.sv
// Next-line instruction prefetch buffer between the I-cache refill port and slow
// instruction memory; every demand refill of line A is followed by a prefetch of A+1.
module icache_line_prefetcher #(
   parameter int unsigned LINE_AW = 28,
   parameter int unsigned LINE_W  = 128,
   parameter int unsigned PF_EN   = 1,
   parameter int unsigned CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               c_read,
   input  logic [LINE_AW-1:0] c_addr,
   output logic [LINE_W-1:0]  c_rdata,
   output logic               c_ready,
   output logic               mem_read,
   output logic [LINE_AW-1:0] mem_addr,
   input  logic [LINE_W-1:0]  mem_rdata,
   input  logic               mem_ready,
   output logic [CNT_W-1:0]   pf_hits,
   output logic [CNT_W-1:0]   pf_wasted
);

   typedef enum logic [1:0] {IDLE, DEMAND, GAP, PREFETCH} state_t;

   state_t             state, state_nxt;
   logic               mem_read_nxt, c_ready_nxt, c_ready_d;
   logic [LINE_AW-1:0] mem_addr_nxt;
   logic [LINE_W-1:0]  c_rdata_nxt;
   logic               buf_valid, buf_valid_nxt;
   logic [LINE_AW-1:0] buf_tag, buf_tag_nxt;
   logic [LINE_W-1:0]  buf_data, buf_data_nxt;
   logic [LINE_AW-1:0] pf_addr, pf_addr_nxt;
   logic               merge, merge_nxt;
   logic               pend, pend_nxt;
   logic [LINE_AW-1:0] pend_addr, pend_addr_nxt;
   logic               gap_dem, gap_dem_nxt;
   logic [CNT_W-1:0]   hits_nxt, wasted_nxt;
   logic               cr, cr_match;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // The cache keeps c_read high during the c_ready cycle and the one after it.
   assign cr       = c_read && !c_ready && !c_ready_d;
   assign cr_match = cr && (c_addr == pf_addr);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         mem_read  <= 1'b0;
         mem_addr  <= '0;
         c_ready   <= 1'b0;
         c_ready_d <= 1'b0;
         c_rdata   <= '0;
         buf_valid <= 1'b0;
         buf_tag   <= '0;
         buf_data  <= '0;
         pf_addr   <= '0;
         merge     <= 1'b0;
         pend      <= 1'b0;
         pend_addr <= '0;
         gap_dem   <= 1'b0;
         pf_hits   <= '0;
         pf_wasted <= '0;
      end else begin
         state     <= state_nxt;
         mem_read  <= mem_read_nxt;
         mem_addr  <= mem_addr_nxt;
         c_ready   <= c_ready_nxt;
         c_ready_d <= c_ready;
         c_rdata   <= c_rdata_nxt;
         buf_valid <= buf_valid_nxt;
         buf_tag   <= buf_tag_nxt;
         buf_data  <= buf_data_nxt;
         pf_addr   <= pf_addr_nxt;
         merge     <= merge_nxt;
         pend      <= pend_nxt;
         pend_addr <= pend_addr_nxt;
         gap_dem   <= gap_dem_nxt;
         pf_hits   <= hits_nxt;
         pf_wasted <= wasted_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      mem_read_nxt  = mem_read;
      mem_addr_nxt  = mem_addr;
      c_ready_nxt   = 1'b0;
      c_rdata_nxt   = c_rdata;
      buf_valid_nxt = buf_valid;
      buf_tag_nxt   = buf_tag;
      buf_data_nxt  = buf_data;
      pf_addr_nxt   = pf_addr;
      merge_nxt     = merge;
      pend_nxt      = pend;
      pend_addr_nxt = pend_addr;
      gap_dem_nxt   = gap_dem;
      hits_nxt      = pf_hits;
      wasted_nxt    = pf_wasted;

      case (state)
         IDLE: begin
            if (cr) begin
               if (buf_valid && (buf_tag == c_addr)) begin
                  c_ready_nxt   = 1'b1;
                  c_rdata_nxt   = buf_data;
                  buf_valid_nxt = 1'b0;
                  hits_nxt      = sat_inc(pf_hits);
                  pf_addr_nxt   = c_addr + 1'b1;
                  gap_dem_nxt   = 1'b0;
                  state_nxt     = GAP;
               end else begin
                  if (buf_valid) wasted_nxt = sat_inc(pf_wasted);
                  buf_valid_nxt = 1'b0;
                  mem_read_nxt  = 1'b1;
                  mem_addr_nxt  = c_addr;
                  state_nxt     = DEMAND;
               end
            end
         end

         DEMAND: begin
            if (mem_ready) begin
               c_ready_nxt  = 1'b1;
               c_rdata_nxt  = mem_rdata;
               mem_read_nxt = 1'b0;
               pf_addr_nxt  = mem_addr + 1'b1;
               gap_dem_nxt  = 1'b0;
               state_nxt    = GAP;
            end
         end

         GAP: begin
            if (gap_dem) begin
               mem_read_nxt = 1'b1;
               mem_addr_nxt = pend_addr;
               gap_dem_nxt  = 1'b0;
               state_nxt    = DEMAND;
            end else if (PF_EN != 0) begin
               mem_read_nxt = 1'b1;
               mem_addr_nxt = pf_addr;
               merge_nxt    = 1'b0;
               pend_nxt     = 1'b0;
               state_nxt    = PREFETCH;
            end else begin
               state_nxt = IDLE;
            end
         end

         PREFETCH: begin
            if (cr_match) begin
               merge_nxt = 1'b1;
            end else if (cr) begin
               pend_nxt      = 1'b1;
               pend_addr_nxt = c_addr;
            end
            // The issued read always runs to completion; the request is resolved afterwards.
            if (mem_ready) begin
               mem_read_nxt = 1'b0;
               merge_nxt    = 1'b0;
               pend_nxt     = 1'b0;
               if (merge || cr_match) begin
                  c_ready_nxt = 1'b1;
                  c_rdata_nxt = mem_rdata;
                  hits_nxt    = sat_inc(pf_hits);
                  pf_addr_nxt = pf_addr + 1'b1;
                  gap_dem_nxt = 1'b0;
                  state_nxt   = GAP;
               end else if (pend || cr) begin
                  wasted_nxt  = sat_inc(pf_wasted);
                  gap_dem_nxt = 1'b1;
                  state_nxt   = GAP;
               end else begin
                  buf_data_nxt  = mem_rdata;
                  buf_tag_nxt   = pf_addr;
                  buf_valid_nxt = 1'b1;
                  state_nxt     = IDLE;
               end
            end
         end

         default: state_nxt = IDLE;
      endcase
   end

endmodule
